// File: rtl/fcw_glide.sv
// Frequency-control-word glide controller: ramps the registered fcw toward a
// handshaked target by a latched step every (rate+1) clocks, clamping on target.
module fcw_glide #(
  parameter int N = 16,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] target,
  input  logic [N-1:0] step,
  input  logic [D-1:0] rate,
  input  logic         target_valid,
  output logic         target_ready,
  input  logic         abort,
  output logic [N-1:0] fcw,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] tgt_q;
  logic [N-1:0] step_q;
  logic [D-1:0] rate_q;
  logic [D-1:0] cnt;

  // One extra bit so an upward step near full scale is seen as overshoot, not wrap.
  logic [N:0]   up_sum;
  logic [N-1:0] down_gap;

  assign up_sum       = {1'b0, fcw} + {1'b0, step_q};
  assign down_gap     = fcw - tgt_q;
  assign target_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      fcw    <= '0;
      tgt_q  <= '0;
      step_q <= '0;
      rate_q <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the default below is overridden later in
      // this block only on the cycle that actually completes a request.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (target_valid) begin
            tgt_q  <= target;
            step_q <= step;
            rate_q <= rate;
            cnt    <= '0;
            if (target == fcw) begin
              done <= 1'b1;
            end else if (step == '0) begin
              fcw  <= target;
              done <= 1'b1;
            end else if (target > fcw) begin
              state <= UP;
            end else begin
              state <= DOWN;
            end
          end
        end

        UP, DOWN: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == rate_q) begin
            cnt <= '0;
            if (state == UP) begin
              if (up_sum >= {1'b0, tgt_q}) begin
                fcw   <= tgt_q;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                fcw <= up_sum[N-1:0];
              end
            end else begin
              // In DOWN fcw is always above tgt_q, so the gap cannot underflow.
              if (down_gap <= step_q) begin
                fcw   <= tgt_q;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                fcw <= fcw - step_q;
              end
            end
          end else begin
            cnt <= cnt + D'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcw_glide.sv
// Self-checking bench for fcw_glide: directed scenarios then random requests,
// compared each clock against a closed-form ramp model.
module tb_fcw_glide;

  localparam int N = 16;
  localparam int D = 12;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] target;
  logic [N-1:0] step;
  logic [D-1:0] rate;
  logic         target_valid;
  logic         target_ready;
  logic         abort;
  logic [N-1:0] fcw;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  // Reference model: a ramp is described by its start, target, step, rate and
  // accept cycle; the value at any cycle follows from those directly.
  longint cyc = 0;
  longint m_fcw = 0;
  bit     m_busy = 0;
  bit     m_done = 0;
  longint r_start, r_tgt, r_step, r_rate, r_t0;
  bit     r_up;

  fcw_glide #(.N(N), .D(D)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .target       (target),
    .step         (step),
    .rate         (rate),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .abort        (abort),
    .fcw          (fcw),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint el, k, v;
    cyc++;
    m_done = 0;
    if (m_busy) begin
      if (abort) begin
        m_busy = 0;
      end else begin
        el = cyc - r_t0;
        if (el % (r_rate + 1) == 0) begin
          k = el / (r_rate + 1);
          if (r_up) v = (r_start + k * r_step > r_tgt) ? r_tgt : r_start + k * r_step;
          else      v = (r_start - k * r_step < r_tgt) ? r_tgt : r_start - k * r_step;
          m_fcw = v;
          if (v == r_tgt) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end else if (target_valid) begin
      if (longint'(target) == m_fcw) begin
        m_done = 1;
      end else if (step == '0) begin
        m_fcw  = longint'(target);
        m_done = 1;
      end else begin
        m_busy  = 1;
        r_start = m_fcw;
        r_tgt   = longint'(target);
        r_step  = longint'(step);
        r_rate  = longint'(rate);
        r_t0    = cyc;
        r_up    = longint'(target) > m_fcw;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".fcw"},   32'(fcw),          32'(m_fcw));
    check({tag, ".done"},  32'(done),         32'(m_done));
    check({tag, ".busy"},  32'(busy),         32'(m_busy));
    check({tag, ".ready"}, 32'(target_ready), 32'(!m_busy));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic req(input logic [N-1:0] t, input logic [N-1:0] s, input logic [D-1:0] r,
                     input string tag);
    target       = t;
    step         = s;
    rate         = r;
    target_valid = 1'b1;
    tick(tag);
    target_valid = 1'b0;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    m_fcw  = 0;
    m_busy = 0;
    m_done = 0;
    check({tag, ".fcw"},   32'(fcw),          32'h0);
    check({tag, ".ready"}, 32'(target_ready), 32'h1);
    check({tag, ".busy"},  32'(busy),         32'h0);
    check({tag, ".done"},  32'(done),         32'h0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b1;
    target       = '0;
    step         = '0;
    rate         = '0;
    target_valid = 1'b0;
    abort        = 1'b0;

    // Reset asserted mid-cycle, before any clock edge has been seen.
    #2;
    reset_n = 1'b0;
    #1;
    check("reset.fcw",   32'(fcw),          32'h0);
    check("reset.ready", 32'(target_ready), 32'h1);
    check("reset.busy",  32'(busy),         32'h0);
    check("reset.done",  32'(done),         32'h0);
    #4;
    reset_n = 1'b1;
    run(2, "idle");

    // Ramp up, rate 0: 0x40, 0x80, 0xC0, 0x100 on consecutive edges.
    req(16'h0100, 16'h0040, 12'd0, "up.accept");
    tick("up.e1"); check("up.e1.val", 32'(fcw), 32'h0040);
    tick("up.e2"); check("up.e2.val", 32'(fcw), 32'h0080);
    tick("up.e3"); check("up.e3.val", 32'(fcw), 32'h00C0);
    tick("up.e4"); check("up.e4.val", 32'(fcw), 32'h0100);
    check("up.e4.done", 32'(done), 32'h1);
    run(2, "up.after");

    // Clamp at full scale without wrap, then clamp at zero without underflow.
    req(16'hFFF0, 16'h0000, 12'd0, "clamp.preset");
    tick("clamp.preset.done");
    req(16'hFFFF, 16'h0020, 12'd2, "clamp.hi.accept");
    run(2, "clamp.hi.wait");
    check("clamp.hi.hold", 32'(fcw), 32'hFFF0);
    tick("clamp.hi.e3");
    check("clamp.hi.val", 32'(fcw), 32'hFFFF);
    check("clamp.hi.done", 32'(done), 32'h1);
    req(16'h0000, 16'h8000, 12'd0, "clamp.lo.accept");
    tick("clamp.lo.e1"); check("clamp.lo.e1.val", 32'(fcw), 32'h7FFF);
    tick("clamp.lo.e2"); check("clamp.lo.e2.val", 32'(fcw), 32'h0000);
    run(2, "clamp.lo.after");

    // Immediate completions: zero step jumps, equal target just pulses done.
    req(16'h1234, 16'h0000, 12'd5, "imm.step0");
    check("imm.step0.val", 32'(fcw), 32'h1234);
    tick("imm.step0.done");
    req(16'h1234, 16'h0010, 12'd0, "imm.equal");
    tick("imm.equal.done");
    check("imm.equal.val", 32'(fcw), 32'h1234);
    run(2, "imm.after");

    // Ignore a request while busy, then abort mid-ramp and hold.
    req(16'h0000, 16'h0000, 12'd0, "abort.preset");
    req(16'h1000, 16'h0100, 12'd0, "abort.accept");
    tick("abort.e1");
    target = 16'h0005; step = 16'h0001; target_valid = 1'b1;
    tick("abort.e2.ignored");
    target_valid = 1'b0;
    tick("abort.e3");
    check("abort.e3.val", 32'(fcw), 32'h0300);
    abort = 1'b1;
    tick("abort.e4");
    abort = 1'b0;
    check("abort.hold", 32'(fcw), 32'h0300);
    check("abort.idle", 32'(target_ready), 32'h1);
    run(4, "abort.after");

    // Back-to-back: new request held through the done cycle is taken next edge.
    req(16'h0400, 16'h0100, 12'd0, "b2b.first");
    target = 16'h0100; step = 16'h0080; rate = 12'd1; target_valid = 1'b1;
    tick("b2b.first.done");
    check("b2b.first.done.flag", 32'(done), 32'h1);
    tick("b2b.second.accept");
    target_valid = 1'b0;
    check("b2b.second.busy", 32'(busy), 32'h1);
    run(13, "b2b.second");
    check("b2b.second.val", 32'(fcw), 32'h0100);

    // Reset mid-ramp drops everything, including any pending done.
    req(16'h8000, 16'h0001, 12'd0, "rst.ramp");
    run(3, "rst.ramp");
    mid_cycle_reset("rst.mid");
    run(2, "rst.after");

    // Random requests, aborts and held-valid during ramps.
    for (int i = 0; i < 3000; i++) begin
      target_valid = ($urandom % 3) == 0;
      target       = ($urandom % 4 == 0) ? fcw : N'($urandom);
      case ($urandom % 4)
        0:       step = '0;
        1:       step = N'($urandom);
        default: step = N'($urandom_range(1, 16'h1800));
      endcase
      rate  = D'($urandom % 4);
      abort = ($urandom % 24) == 0;
      tick("rand");
    end
    target_valid = 1'b0;
    abort        = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
